// File: rtl/dec_pkg.sv
// Shared definitions for the decrypt-function front end: frame field
// positions, error encodings, function identifiers and the frame checker.
package dec_pkg;

    localparam int RAND_MSB    = 77;
    localparam int RAND_LSB    = 67;
    localparam int CT_MSB      = 66;
    localparam int CT_LSB      = 6;
    localparam int SEL_MSB     = 5;
    localparam int SEL_LSB     = 0;
    localparam int FRAME_BYTES = 10;
    localparam int FRAME_W     = 80;
    localparam int DATA_W      = 78;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_PAD  = 2'd1;
    localparam logic [1:0] ERR_SEL  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [5:0] DEC_FN_1 = 6'd1;
    localparam logic [5:0] DEC_FN_2 = 6'd2;
    localparam logic [5:0] DEC_FN_3 = 6'd3;
    localparam logic [5:0] DEC_FN_4 = 6'd4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } asm_state_t;

    // Classify a complete frame; a bad pad outranks a wrong selector.
    function automatic logic [1:0] frame_check(input logic [FRAME_W-1:0] frame,
                                               input logic [5:0]         fn_id);
        logic [1:0] code;
        if (frame[FRAME_W-1:DATA_W] != 2'b00) begin
            code = ERR_PAD;
        end else if (frame[SEL_MSB:SEL_LSB] != fn_id) begin
            code = ERR_SEL;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/dec_out_slot.sv
// One-entry valid/ready holding register. A load in the same cycle as a
// consume replaces the old entry and keeps the slot valid.
module dec_out_slot
    import dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Slot register: load wins over consume, data is stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dec_frame_assembler.sv
// Byte-stream to 78-bit frame assembler: collects 10 bytes MSB-first,
// checks pad and selector, hands good frames to a one-entry output slot
// and counts dropped frames (bad pad, wrong selector, inter-byte timeout).
module dec_frame_assembler
    import dec_pkg::*;
#(
    parameter int unsigned FN_ID   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ERRW    = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic [ERRW-1:0]   err_count
);

    localparam logic [5:0]      FN_SEL   = 6'(FN_ID);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]      LAST_IDX = 4'(FRAME_BYTES - 1);
    localparam logic [ERRW-1:0] CNT_ONE  = ERRW'(1);

    asm_state_t            r_state;
    asm_state_t            w_state_nxt;
    logic [3:0]            r_byte_cnt;
    logic [71:0]           r_shift;
    logic [15:0]           r_timer;
    logic                  r_err_pulse;
    logic [1:0]            r_err_code;
    logic [ERRW-1:0]       r_err_count;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_timeout;
    logic                  w_load;
    logic                  w_drop;
    logic [1:0]            w_drop_code;
    logic [1:0]            w_chk;
    logic [FRAME_W-1:0]    w_frame;
    logic                  w_slot_valid;
    logic [DATA_W-1:0]     w_slot_data;

    // The final byte may only enter when the slot is free or emptying now.
    assign w_in_ready = !((r_byte_cnt == LAST_IDX) && w_slot_valid && !out_ready);

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a first byte opens a frame, completion or timeout closes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (w_last || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, completion check on the incoming 10th byte, timeout.
    always_comb begin
        w_accept    = in_valid && w_in_ready;
        w_frame     = {r_shift, in_data};
        w_chk       = frame_check(w_frame, FN_SEL);
        w_last      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_last    = 1'b0;
                w_timeout = 1'b0;
            end
            ST_COLLECT: begin
                w_last    = w_accept && (r_byte_cnt == LAST_IDX);
                w_timeout = !w_accept && w_in_ready && (r_timer == TMO_LAST);
            end
            default: begin
                w_last    = 1'b0;
                w_timeout = 1'b0;
            end
        endcase
        w_load = w_last && (w_chk == ERR_NONE);
        if (w_last && (w_chk != ERR_NONE)) begin
            w_drop      = 1'b1;
            w_drop_code = w_chk;
        end else if (w_timeout) begin
            w_drop      = 1'b1;
            w_drop_code = ERR_TMO;
        end else begin
            w_drop      = 1'b0;
            w_drop_code = ERR_NONE;
        end
    end

    // Assembly datapath: byte counter, shift register and inter-byte timer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_byte_cnt <= 4'd0;
            r_shift    <= 72'd0;
            r_timer    <= 16'd0;
        end else if (w_last || w_timeout) begin
            r_byte_cnt <= 4'd0;
            r_shift    <= 72'd0;
            r_timer    <= 16'd0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
            r_shift    <= {r_shift[63:0], in_data};
            r_timer    <= 16'd0;
        end else if ((r_state == ST_COLLECT) && w_in_ready) begin
            r_timer    <= r_timer + 16'd1;
        end else begin
            r_timer    <= r_timer;
        end
    end

    // Drop reporting: one-cycle pulse, sticky cause, saturating counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= {ERRW{1'b0}};
        end else if (w_drop) begin
            r_err_pulse <= 1'b1;
            r_err_code  <= w_drop_code;
            if (!(&r_err_count)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_err_pulse <= 1'b0;
        end
    end

    dec_out_slot u_slot (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_load  (w_load),
        .i_data  (w_frame[DATA_W-1:0]),
        .i_ready (out_ready),
        .o_valid (w_slot_valid),
        .o_data  (w_slot_data)
    );

    assign in_ready  = w_in_ready;
    assign data_1    = w_slot_data;
    assign out_valid = w_slot_valid;
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;

endmodule
